// File: rtl/ctrl_pipe_pkg.sv
// Shared control-bundle type, ALU codes and forward-select encodings for the EX/MEM/WB control pipe.
// Also holds the single forwarding-priority function, so the A and B operands cannot diverge.
package ctrl_pipe_pkg;

    typedef struct packed {
        logic       rfwe;
        logic       dmwe;
        logic       alumux;
        logic       mtorf;
        logic       rfdsel;
        logic       branch;
        logic       jump;
        logic [2:0] alu;
        logic [4:0] wreg;
        logic       valid;
    } ctrl_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SLLV = 3'b110;
    localparam logic [2:0] ALU_SRAV = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam ctrl_t BUBBLE = '0;

    // The younger producer in MEM wins over WB; $0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic       rfwe_m,
                                           input logic [4:0] wreg_m,
                                           input logic       rfwe_w,
                                           input logic [4:0] wreg_w,
                                           input logic [4:0] src);
        if (rfwe_m && (wreg_m != 5'd0) && (wreg_m == src)) return FWD_MEM;
        if (rfwe_w && (wreg_w != 5'd0) && (wreg_w == src)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/ctrl_hazard_detect.sv
// Stall, flush and EX operand-forward selection from the current stage controls.
// Purely combinational, zero latency.
// No backpressure of its own: it produces the stall/flush that the pipeline obeys.
module ctrl_hazard_detect
    import ctrl_pipe_pkg::*;
(
    input  logic       mtorf_e_i,
    input  logic       rfwe_e_i,
    input  logic       branch_e_i,
    input  logic       zero_e_i,
    input  logic [4:0] wreg_e_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic       jump_d_i,
    input  logic       valid_d_i,
    input  logic       rfwe_m_i,
    input  logic [4:0] wreg_m_i,
    input  logic       rfwe_w_i,
    input  logic [4:0] wreg_w_i,
    output logic       stall_o,
    output logic       flush_d_o,
    output logic       flush_e_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);
    logic br_taken;
    logic load_use;

    assign br_taken = branch_e_i & zero_e_i;
    assign load_use = mtorf_e_i & rfwe_e_i & (wreg_e_i != 5'd0)
                    & ((wreg_e_i == rs_d_i) | (wreg_e_i == rt_d_i));

    // A taken branch makes the instruction in D wrong-path, so it must not stall.
    assign stall_o   = load_use & ~br_taken;
    assign flush_e_o = br_taken | stall_o;
    // A jump held by a stall is re-seen in D next cycle and flushes then.
    assign flush_d_o = br_taken | (jump_d_i & valid_d_i & ~stall_o);

    assign fwd_a_o = fwd_sel(rfwe_m_i, wreg_m_i, rfwe_w_i, wreg_w_i, rs_e_i);
    assign fwd_b_o = fwd_sel(rfwe_m_i, wreg_m_i, rfwe_w_i, wreg_w_i, rt_e_i);

endmodule

// File: rtl/ctrl_pipeline_hazard.sv
// Carries decoded controls through E/M/W and resolves load-use, branch/jump and forwarding hazards.
// One cycle per stage (D->W in 3); stall/flush/forward are combinational.
// Load-use stall holds F/D and bubbles E while M and W keep advancing.
module ctrl_pipeline_hazard
    import ctrl_pipe_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STALL_W = 16
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               RFWED,
    input  logic               DMWED,
    input  logic               ALUMUXInSelD,
    input  logic               MtoRFSelD,
    input  logic               RFDSelIND,
    input  logic               BranchD,
    input  logic               JumpD,
    input  logic [2:0]         ALUControlD,
    input  logic               ValidD,
    input  logic [4:0]         RsD,
    input  logic [4:0]         RtD,
    input  logic [4:0]         RdD,
    input  logic               ZeroE,
    output logic               RFWEE,
    output logic               DMWEE,
    output logic               ALUMUXInSelE,
    output logic               MtoRFSelE,
    output logic               RFDSelINE,
    output logic               BranchE,
    output logic [2:0]         ALUControlE,
    output logic [4:0]         RsE,
    output logic [4:0]         RtE,
    output logic               RFWEM,
    output logic               DMWEM,
    output logic               MtoRFSelM,
    output logic               RFWEW,
    output logic               MtoRFSelW,
    output logic [4:0]         WriteRegE,
    output logic [4:0]         WriteRegM,
    output logic [4:0]         WriteRegW,
    output logic               StallF,
    output logic               StallD,
    output logic               FlushD,
    output logic               FlushE,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic [CNT_W-1:0]   RetiredCnt,
    output logic [STALL_W-1:0] StallCnt
);
    ctrl_t              d_bundle, e_d, e_q, m_q, w_q;
    logic [4:0]         rs_e_d, rs_e_q, rt_e_d, rt_e_q;
    logic               stall, flush_e, flush_d;
    logic [CNT_W-1:0]   retired_d, retired_q;
    logic [STALL_W-1:0] stall_cnt_d, stall_cnt_q;
    logic               unused_bits;

    // An invalid D slot enters as a bubble so don't-care decoder fields never reach a write enable.
    always_comb begin
        d_bundle = BUBBLE;
        if (ValidD) begin
            d_bundle.rfwe   = RFWED;
            d_bundle.dmwe   = DMWED;
            d_bundle.alumux = ALUMUXInSelD;
            d_bundle.mtorf  = MtoRFSelD;
            d_bundle.rfdsel = RFDSelIND;
            d_bundle.branch = BranchD & ~JumpD;
            d_bundle.jump   = JumpD;
            d_bundle.alu    = ALUControlD;
            d_bundle.wreg   = RFDSelIND ? RdD : RtD;
            d_bundle.valid  = 1'b1;
        end
    end

    assign e_d    = flush_e ? BUBBLE : d_bundle;
    assign rs_e_d = flush_e ? 5'd0 : RsD;
    assign rt_e_d = flush_e ? 5'd0 : RtD;

    assign retired_d   = retired_q + CNT_W'(m_q.valid);
    assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + STALL_W'(1) : stall_cnt_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            e_q         <= BUBBLE;
            m_q         <= BUBBLE;
            w_q         <= BUBBLE;
            rs_e_q      <= 5'd0;
            rt_e_q      <= 5'd0;
            retired_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= e_q;
            w_q         <= m_q;
            rs_e_q      <= rs_e_d;
            rt_e_q      <= rt_e_d;
            retired_q   <= retired_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    ctrl_hazard_detect u_hazard (
        .mtorf_e_i  (e_q.mtorf),
        .rfwe_e_i   (e_q.rfwe),
        .branch_e_i (e_q.branch),
        .zero_e_i   (ZeroE),
        .wreg_e_i   (e_q.wreg),
        .rs_e_i     (rs_e_q),
        .rt_e_i     (rt_e_q),
        .rs_d_i     (RsD),
        .rt_d_i     (RtD),
        .jump_d_i   (JumpD),
        .valid_d_i  (ValidD),
        .rfwe_m_i   (m_q.rfwe),
        .wreg_m_i   (m_q.wreg),
        .rfwe_w_i   (w_q.rfwe),
        .wreg_w_i   (w_q.wreg),
        .stall_o    (stall),
        .flush_d_o  (flush_d),
        .flush_e_o  (flush_e),
        .fwd_a_o    (ForwardAE),
        .fwd_b_o    (ForwardBE)
    );

    assign RFWEE        = e_q.rfwe;
    assign DMWEE        = e_q.dmwe;
    assign ALUMUXInSelE = e_q.alumux;
    assign MtoRFSelE    = e_q.mtorf;
    assign RFDSelINE    = e_q.rfdsel;
    assign BranchE      = e_q.branch;
    assign ALUControlE  = e_q.alu;
    assign WriteRegE    = e_q.wreg;
    assign RsE          = rs_e_q;
    assign RtE          = rt_e_q;
    assign RFWEM        = m_q.rfwe;
    assign DMWEM        = m_q.dmwe;
    assign MtoRFSelM    = m_q.mtorf;
    assign WriteRegM    = m_q.wreg;
    assign RFWEW        = w_q.rfwe;
    assign MtoRFSelW    = w_q.mtorf;
    assign WriteRegW    = w_q.wreg;
    assign StallF       = stall;
    assign StallD       = stall;
    assign FlushD       = flush_d;
    assign FlushE       = flush_e;
    assign RetiredCnt   = retired_q;
    assign StallCnt     = stall_cnt_q;

    // Later stages only need a subset of the bundle; the rest travels for uniformity.
    assign unused_bits = ^{e_q.jump, m_q.alumux, m_q.rfdsel, m_q.branch, m_q.jump, m_q.alu,
                           w_q.dmwe, w_q.alumux, w_q.rfdsel, w_q.branch, w_q.jump, w_q.alu,
                           w_q.valid};

endmodule

// File: tb/tb_ctrl_pipeline_hazard.sv
// Directed bench for ctrl_pipeline_hazard: reset, retire, load-use, forwarding, branch, jump, saturation.
module tb_ctrl_pipeline_hazard;
    import ctrl_pipe_pkg::*;

    localparam int CNT_W   = 32;
    // Narrow stall counter so its saturation point is reachable in a few dozen cycles.
    localparam int STALL_W = 4;

    logic CLK = 1'b0;
    logic RSTn;
    logic RFWED, DMWED, ALUMUXInSelD, MtoRFSelD, RFDSelIND, BranchD, JumpD, ValidD, ZeroE;
    logic [2:0] ALUControlD;
    logic [4:0] RsD, RtD, RdD;
    logic RFWEE, DMWEE, ALUMUXInSelE, MtoRFSelE, RFDSelINE, BranchE;
    logic [2:0] ALUControlE;
    logic [4:0] RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RFWEM, DMWEM, MtoRFSelM, RFWEW, MtoRFSelW;
    logic StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] RetiredCnt;
    logic [STALL_W-1:0] StallCnt;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    ctrl_pipeline_hazard #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .RFWED(RFWED), .DMWED(DMWED), .ALUMUXInSelD(ALUMUXInSelD), .MtoRFSelD(MtoRFSelD),
        .RFDSelIND(RFDSelIND), .BranchD(BranchD), .JumpD(JumpD), .ALUControlD(ALUControlD),
        .ValidD(ValidD), .RsD(RsD), .RtD(RtD), .RdD(RdD), .ZeroE(ZeroE),
        .RFWEE(RFWEE), .DMWEE(DMWEE), .ALUMUXInSelE(ALUMUXInSelE), .MtoRFSelE(MtoRFSelE),
        .RFDSelINE(RFDSelINE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RsE(RsE), .RtE(RtE), .RFWEM(RFWEM), .DMWEM(DMWEM), .MtoRFSelM(MtoRFSelM),
        .RFWEW(RFWEW), .MtoRFSelW(MtoRFSelW),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .RetiredCnt(RetiredCnt), .StallCnt(StallCnt)
    );

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive(input logic v, rfwe, dmwe, amux, mtorf, rfdsel, br, jmp,
                         input logic [2:0] alu, input logic [4:0] rs, rt, rd);
        ValidD = v; RFWED = rfwe; DMWED = dmwe; ALUMUXInSelD = amux; MtoRFSelD = mtorf;
        RFDSelIND = rfdsel; BranchD = br; JumpD = jmp; ALUControlD = alu;
        RsD = rs; RtD = rt; RdD = rd;
    endtask

    task automatic d_nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 5'd0, 5'd0, 5'd0);
    endtask
    task automatic d_add(input logic [4:0] rs, rt, rd);
        drive(1, 1, 0, 0, 0, 1, 0, 0, ALU_ADD, rs, rt, rd);
    endtask
    task automatic d_lw(input logic [4:0] rs, rt);
        drive(1, 1, 0, 1, 1, 0, 0, 0, ALU_ADD, rs, rt, 5'd0);
    endtask
    task automatic d_sw(input logic [4:0] rs, rt);
        drive(1, 0, 1, 1, 0, 0, 0, 0, ALU_ADD, rs, rt, 5'd0);
    endtask
    task automatic d_jump(input logic [4:0] rs);
        drive(1, 0, 0, 0, 0, 0, 1'bx, 1, ALU_ADD, rs, 5'd0, 5'd0);
    endtask
    task automatic drain();
        d_nop();
        ZeroE = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        d_nop();
        ZeroE = 1'b0;
        #2;
        tests++; if (RetiredCnt !== '0) begin fails++; $display("FAIL reset_retired got %0h exp 0", RetiredCnt); end
        tests++; if (StallCnt !== '0) begin fails++; $display("FAIL reset_stallcnt got %0h exp 0", StallCnt); end
        tests++; if ({RFWEE, RFWEM, RFWEW, WriteRegE} !== 8'd0) begin fails++; $display("FAIL reset_stage got %0h exp 0", {RFWEE, RFWEM, RFWEW, WriteRegE}); end
        tests++; if ({StallD, FlushD, FlushE, ForwardAE, ForwardBE} !== 7'd0) begin fails++; $display("FAIL reset_hazard got %0h exp 0", {StallD, FlushD, FlushE, ForwardAE, ForwardBE}); end
        #1 RSTn = 1'b1;
    endtask

    task automatic test_retire();
        for (int k = 1; k <= 4; k++) begin
            d_add(5'd20, 5'd21, 5'(k));
            if (k < 4) tick();
        end
        tick();
        d_nop();
        tick();
        tests++; if (RetiredCnt !== 32'd3) begin fails++; $display("FAIL retire_two_after got %0d exp 3", RetiredCnt); end
        tick();
        tests++; if (RetiredCnt !== 32'd4) begin fails++; $display("FAIL retire_three_after got %0d exp 4", RetiredCnt); end
        tests++; if ({RFWEW, WriteRegW} !== {1'b1, 5'd4}) begin fails++; $display("FAIL retire_wb got %0h exp 24", {RFWEW, WriteRegW}); end
    endtask

    task automatic test_load_use();
        drain();
        d_lw(5'd1, 5'd8);
        tick();
        tests++; if ({MtoRFSelE, RFWEE, WriteRegE} !== {2'b11, 5'd8}) begin fails++; $display("FAIL lu_lw_in_e got %0h exp 68", {MtoRFSelE, RFWEE, WriteRegE}); end
        d_add(5'd8, 5'd9, 5'd10);
        #1;
        tests++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin fails++; $display("FAIL lu_stall got %b exp 1110", {StallF, StallD, FlushE, FlushD}); end
        tick();
        tests++; if ({RFWEE, DMWEE, MtoRFSelE, ALUMUXInSelE, RFDSelINE, BranchE, ALUControlE, WriteRegE} !== 14'd0) begin fails++; $display("FAIL lu_bubble got %0h exp 0", {RFWEE, DMWEE, MtoRFSelE, ALUMUXInSelE, RFDSelINE, BranchE, ALUControlE, WriteRegE}); end
        tests++; if ({StallD, FlushE} !== 2'b00) begin fails++; $display("FAIL lu_one_cycle got %b exp 00", {StallD, FlushE}); end
        tests++; if (StallCnt !== 4'd1) begin fails++; $display("FAIL lu_stallcnt got %0d exp 1", StallCnt); end
        tick();
        tests++; if ({WriteRegE, RsE} !== {5'd10, 5'd8}) begin fails++; $display("FAIL lu_add_in_e got %0h exp 148", {WriteRegE, RsE}); end
        tests++; if (ForwardAE !== FWD_WB) begin fails++; $display("FAIL lu_fwd_from_wb got %b exp 01", ForwardAE); end
    endtask

    task automatic test_forward();
        drain();
        d_add(5'd1, 5'd2, 5'd5); tick();
        d_add(5'd3, 5'd4, 5'd5); tick();
        d_add(5'd5, 5'd5, 5'd7); tick();
        tests++; if ({ForwardAE, ForwardBE} !== 4'b1010) begin fails++; $display("FAIL fwd_mem_prio got %b exp 1010", {ForwardAE, ForwardBE}); end
        drain();
        d_add(5'd1, 5'd2, 5'd5); tick();
        d_sw(5'd3, 5'd5); tick();
        d_add(5'd5, 5'd6, 5'd7); tick();
        tests++; if ({RFWEM, WriteRegM} !== {1'b0, 5'd5}) begin fails++; $display("FAIL fwd_sw_in_m got %0h exp 05", {RFWEM, WriteRegM}); end
        tests++; if ({ForwardAE, ForwardBE} !== 4'b0100) begin fails++; $display("FAIL fwd_wb got %b exp 0100", {ForwardAE, ForwardBE}); end
        drain();
        d_add(5'd1, 5'd2, 5'd0); tick();
        d_add(5'd3, 5'd4, 5'd0); tick();
        d_add(5'd0, 5'd0, 5'd7); tick();
        tests++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin fails++; $display("FAIL fwd_reg0 got %b exp 0000", {ForwardAE, ForwardBE}); end
    endtask

    task automatic test_branch();
        drain();
        drive(1, 1, 0, 0, 1, 0, 1, 0, ALU_SUB, 5'd7, 5'd8, 5'd0);
        tick();
        tests++; if ({BranchE, ALUControlE} !== {1'b1, ALU_SUB}) begin fails++; $display("FAIL br_in_e got %b exp 1010", {BranchE, ALUControlE}); end
        d_add(5'd8, 5'd9, 5'd10);
        ZeroE = 1'b1;
        #1;
        tests++; if ({FlushD, FlushE, StallD, StallF} !== 4'b1100) begin fails++; $display("FAIL br_taken got %b exp 1100", {FlushD, FlushE, StallD, StallF}); end
        ZeroE = 1'b0;
        #1;
        tests++; if ({FlushD, FlushE, StallD} !== 3'b011) begin fails++; $display("FAIL br_not_taken got %b exp 011", {FlushD, FlushE, StallD}); end
        d_nop();
    endtask

    task automatic test_jump();
        drain();
        d_jump(5'd3);
        #1;
        tests++; if ({FlushD, FlushE} !== 2'b10) begin fails++; $display("FAIL jmp_flush got %b exp 10", {FlushD, FlushE}); end
        tick();
        tests++; if ({BranchE, RFWEE, DMWEE} !== 3'b000) begin fails++; $display("FAIL jmp_sanitise got %b exp 000", {BranchE, RFWEE, DMWEE}); end
        drain();
        d_lw(5'd1, 5'd8);
        tick();
        d_jump(5'd8);
        #1;
        tests++; if ({FlushD, StallD} !== 2'b01) begin fails++; $display("FAIL jmp_in_stall got %b exp 01", {FlushD, StallD}); end
        tick();
        tests++; if ({FlushD, StallD} !== 2'b10) begin fails++; $display("FAIL jmp_after_stall got %b exp 10", {FlushD, StallD}); end
    endtask

    task automatic test_saturate();
        drain();
        for (int i = 0; i < 17; i++) begin
            d_lw(5'd1, 5'd8); tick();
            d_add(5'd8, 5'd9, 5'd10); tick();
        end
        tests++; if (StallCnt !== 4'hF) begin fails++; $display("FAIL sat_reached got %0h exp f", StallCnt); end
        d_lw(5'd1, 5'd8); tick();
        d_add(5'd8, 5'd9, 5'd10);
        #1;
        tests++; if (StallD !== 1'b1) begin fails++; $display("FAIL sat_stall_again got %b exp 1", StallD); end
        tick();
        tests++; if (StallCnt !== 4'hF) begin fails++; $display("FAIL sat_sticks got %0h exp f", StallCnt); end
    endtask

    task automatic test_reset_mid();
        drain();
        d_add(5'd1, 5'd2, 5'd3); tick();
        d_lw(5'd1, 5'd8); tick();
        d_add(5'd8, 5'd9, 5'd10);
        #1 RSTn = 1'b0;
        #1;
        tests++; if ({StallD, FlushD, FlushE, ForwardAE, ForwardBE} !== 7'd0) begin fails++; $display("FAIL rstmid_hazard got %0h exp 0", {StallD, FlushD, FlushE, ForwardAE, ForwardBE}); end
        tests++; if ({RFWEE, MtoRFSelE, WriteRegE, RFWEM, WriteRegM, RFWEW} !== 14'd0) begin fails++; $display("FAIL rstmid_stage got %0h exp 0", {RFWEE, MtoRFSelE, WriteRegE, RFWEM, WriteRegM, RFWEW}); end
        tests++; if ({RetiredCnt, StallCnt} !== '0) begin fails++; $display("FAIL rstmid_counters got %0h exp 0", {RetiredCnt, StallCnt}); end
        #1 RSTn = 1'b1;
        tick();
        tests++; if ({RFWEE, RFDSelINE, WriteRegE, RsE, RtE} !== {2'b11, 5'd10, 5'd8, 5'd9}) begin fails++; $display("FAIL rstmid_first_load got %0h exp %0h", {RFWEE, RFDSelINE, WriteRegE, RsE, RtE}, {2'b11, 5'd10, 5'd8, 5'd9}); end
    endtask

    initial begin
        test_reset();
        test_retire();
        test_load_use();
        test_forward();
        test_branch();
        test_jump();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline_hazard.md
# ctrl_pipeline_hazard

Carries the control bundle produced by the decode-stage control unit down the EX, MEM and WB pipeline registers. It also resolves the hazards those controls create: load-use stalls, branch and jump flushes, and EX-stage operand forwarding. It sits between the decode-stage control unit and the datapath pipeline registers and consumes every control output the decoder drives. It also keeps retired-instruction and stall-cycle counters for bring-up.

## Interface
Parameters:
- CNT_W, default 32: width of the retired-instruction counter.
- STALL_W, default 16: width of the saturating stall counter.

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RSTn  in  1  asynchronous, active-low reset
- RFWED, DMWED, ALUMUXInSelD, MtoRFSelD, RFDSelIND, BranchD, JumpD  in  1 each  decoded controls for the instruction in D
- ALUControlD  in  3  decoded ALU operation
- ValidD  in  1  D holds a real instruction (0 after FlushD)
- RsD, RtD, RdD  in  5 each  register fields in D
- ZeroE  in  1  ALU zero flag of the instruction in E
- RFWEE, DMWEE, ALUMUXInSelE, MtoRFSelE, RFDSelINE, BranchE  out  1 each  EX-stage controls
- ALUControlE  out  3  EX-stage ALU operation
- RsE, RtE  out  5 each  source fields in E
- RFWEM, DMWEM, MtoRFSelM, RFWEW, MtoRFSelW  out  1 each  MEM-stage and WB-stage controls
- WriteRegE, WriteRegM, WriteRegW  out  5 each  destination register per stage
- StallF, StallD  out  1 each  hold the PC and the F/D register
- FlushD, FlushE  out  1 each  squash the F/D register; insert a bubble into E
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 01 WB result, 10 MEM ALU result
- RetiredCnt  out  CNT_W  instructions that reached WB with ValidW=1
- StallCnt  out  STALL_W  cycles with StallD=1, saturating

## Operation
- **WriteRegE** is latched as RdD when RFDSelIND=1, otherwise RtD.
- **Control sanitising.** The decoder drives x on don't-care fields. This block must not propagate them into write enables.
  - BranchE is latched as BranchD & ~JumpD.
  - A bubble forces all 1-bit controls and the valid bit to 0, ALUControl to 000 and WriteReg to 0.
- **Load-use stall.** Asserted when all of the following hold: MtoRFSelE=1, RFWEE=1, WriteRegE≠0, and WriteRegE equals RsD or RtD. Then:
  - StallF=StallD=1;
  - FlushE=1.
- **Branch taken.** BranchE=1 and ZeroE=1. Then:
  - FlushD=1 and FlushE=1;
  - the stall is suppressed, because the stalled instruction is wrong-path.
- **Jump.** JumpD=1 with ValidD=1 asserts FlushD=1, unless a stall is active that cycle. During a stall the jump is re-evaluated the next cycle.
- **Flush priority.** Branch-taken > load-use stall > jump.
- **Forwarding for ForwardAE** (ForwardBE is identical, with RtE in place of RsE):
  - 10 when RFWEM=1, WriteRegM≠0 and WriteRegM=RsE;
  - else 01 when RFWEW=1, WriteRegW≠0 and WriteRegW=RsE;
  - else 00.
  - MEM takes priority over WB.
- **Register 0** never matches, so a stall or forward on $0 is never generated.
- **Counters.**
  - RetiredCnt wraps modulo 2^CNT_W.
  - StallCnt sticks at its all-ones value.

## Timing
- **Combinational outputs:** Stall, Flush and Forward outputs are combinational from current inputs and stage registers. Zero-cycle latency.
- **Registered outputs:** all E/M/W outputs. D→E, E→M and M→W each take 1 cycle, so a decoded instruction reaches W 3 cycles after it is in D.
- **FlushE:** the E register loads the bubble at the next edge.
- **Stall:** E receives the bubble while D is held by the datapath. M and W continue to advance.
- **Reset:**
  - RSTn=0 immediately clears every stage register, WriteReg, and both counters to 0.
  - Stall, Flush and Forward outputs evaluate to 0 because all stage valids and enables are 0.
  - Reset mid-stall or mid-flush discards all in-flight state.
  - The first edge after release loads the D inputs normally.

## Structure
- **ctrl_pipe_pkg** holds:
  - the control-bundle struct (7 flags, 3-bit ALU code, 5-bit WriteReg, valid);
  - the BUBBLE constant;
  - the ALU codes: add 000, sub 010, sll 101, sllv 110, srav 111;
  - the forward-select encodings FWD_RF, FWD_WB, FWD_MEM.
- **ctrl_hazard_detect** is the only sub-module. It is purely combinational and computes stall, flush and forward from the stage bundles. The top level holds the three pipeline registers and the counters.

## Test plan
- **Load-use.** lw $8 in E (MtoRFSelE=1, WriteRegE=8), then add with RsD=8 → StallF=StallD=FlushE=1 for exactly 1 cycle. The next cycle has all E controls 0 and StallCnt=1.
- **Forward priority.** add writing $5 in M and another writing $5 in W, RsE=5 → ForwardAE=10. With M's write removed → 01. With RsE=0 and writes to $0 → 00.
- **Branch.** beq in E with ZeroE=1 and a simultaneous load-use condition in D → FlushD=FlushE=1, StallD=0. With ZeroE=0 → no flush.
- **Jump.** JumpD=1 with BranchD=x → FlushD=1 and BranchE=0 after the edge. The same jump during a stall → FlushD=0 that cycle, 1 the next.
- **Retire and saturate.** Stream 4 valid adds → RetiredCnt=4 three cycles after the last is in D. Force StallCnt to 0xFFFF, stall again → stays 0xFFFF.
- **Reset.** Assert RSTn=0 mid-stream between edges → all outputs 0 immediately. Release → the instruction in D appears in E after 1 edge.
